// File: rtl/phase_marker_tracker.sv
// phase_marker_tracker
//   Watches the commit streams of two lock-stepped cores (base = core 0,
//   variant = core 1), decodes phase-marker instructions
//   (slti x0,x0,imm with inst[19:0] == 20'h02013) and tracks one phase
//   interval per core. Completed intervals are timestamped and pushed into
//   a shared event FIFO. Protocol errors and base/variant divergence are
//   flagged.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   clear                       sync clear of sticky flags and counters
//   base_valid/base_inst        base commit lanes (lane i at [32i+31:32i])
//   vnt_valid/vnt_inst          variant commit lanes
//   ev_valid/ev_ready/ev_data   event FIFO head {core, phase, start_ts, duration}
//   base_/vnt_active            core is inside a phase
//   base_/vnt_phase             current or last phase id
//   base_/vnt_done_cnt          completed phases (saturating)
//   aligned                     both idle with equal done counts
//   diverged                    sticky phase divergence flag
//   proto_err                   sticky protocol error, bit0 base, bit1 variant
//   drop_cnt                    markers ignored or records lost (saturating)
module phase_marker_tracker #(
    parameter int unsigned NUM_LANES  = 2,
    parameter int unsigned TS_W       = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned NUM_PHASES = 7,
    parameter int unsigned PHASE_W    = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic [NUM_LANES-1:0]       base_valid,
    input  logic [32*NUM_LANES-1:0]    base_inst,
    input  logic [NUM_LANES-1:0]       vnt_valid,
    input  logic [32*NUM_LANES-1:0]    vnt_inst,
    output logic                       ev_valid,
    input  logic                       ev_ready,
    output logic [PHASE_W+2*TS_W:0]    ev_data,
    output logic                       base_active,
    output logic                       vnt_active,
    output logic [PHASE_W-1:0]         base_phase,
    output logic [PHASE_W-1:0]         vnt_phase,
    output logic [CNT_W-1:0]           base_done_cnt,
    output logic [CNT_W-1:0]           vnt_done_cnt,
    output logic                       aligned,
    output logic                       diverged,
    output logic [1:0]                 proto_err,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int unsigned NCORE = 2;
    localparam int unsigned REC_W = 1 + PHASE_W + 2 * TS_W;
    localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned DW    = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [19:0]      MARKER_OPC = 20'h02013;

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    // Per-core views of the commit lanes
    logic [NUM_LANES-1:0]    lane_v [NCORE];
    logic [32*NUM_LANES-1:0] lane_i [NCORE];

    assign lane_v[0] = base_valid;
    assign lane_v[1] = vnt_valid;
    assign lane_i[0] = base_inst;
    assign lane_i[1] = vnt_inst;

    // Registered state
    logic [TS_W-1:0]    ts_q;
    state_t             state_q [NCORE];
    logic [PHASE_W-1:0] phase_q [NCORE];
    logic [TS_W-1:0]    start_q [NCORE];
    logic [CNT_W-1:0]   done_q  [NCORE];
    logic [REC_W-1:0]   mem_q   [FIFO_DEPTH];
    logic [AW-1:0]      rd_q;
    logic [AW-1:0]      wr_q;
    logic [CW-1:0]      count_q;
    logic [CNT_W-1:0]   drop_q;
    logic [1:0]         err_q;
    logic               div_q;
    logic               aligned_q;

    // Decode results
    logic               mk_hit   [NCORE];
    logic               mk_end   [NCORE];
    logic [PHASE_W-1:0] mk_phase [NCORE];
    logic [CNT_W-1:0]   mk_extra [NCORE];
    logic [31:0]        dec_inst;
    logic [11:0]        dec_imm;
    logic               dec_ok;

    // Next-state signals
    state_t             state_d [NCORE];
    logic [PHASE_W-1:0] phase_d [NCORE];
    logic [TS_W-1:0]    start_d [NCORE];
    logic [CNT_W-1:0]   done_d  [NCORE];
    logic               push    [NCORE];
    logic               err_set [NCORE];
    logic [REC_W-1:0]   rec     [NCORE];

    logic               pop;
    logic [CW-1:0]      free0;
    logic [CW-1:0]      free1;
    logic               acc0;
    logic               acc1;
    logic [1:0]         lost;
    logic [AW-1:0]      wr1;
    logic [CW-1:0]      count_d;

    logic [DW-1:0]      drop_sum;
    logic [CNT_W-1:0]   drop_d;
    logic [1:0]         err_d;
    logic               aligned_d;
    logic               div_d;

    // Marker decode: lowest-index marker lane wins, extra marker lanes are counted
    always_comb begin
        dec_inst = '0;
        dec_imm  = '0;
        dec_ok   = 1'b0;
        for (int c = 0; c < int'(NCORE); c++) begin
            mk_hit[c]   = 1'b0;
            mk_end[c]   = 1'b0;
            mk_phase[c] = '0;
            mk_extra[c] = '0;
            for (int l = 0; l < int'(NUM_LANES); l++) begin
                dec_inst = lane_i[c][32*l +: 32];
                dec_imm  = dec_inst[31:20];
                dec_ok   = lane_v[c][l]
                           && (dec_inst[19:0] == MARKER_OPC)
                           && ((dec_imm >> (PHASE_W + 1)) == 12'd0)
                           && (32'(PHASE_W'(dec_imm >> 1)) < NUM_PHASES);
                if (dec_ok) begin
                    if (!mk_hit[c]) begin
                        mk_hit[c]   = 1'b1;
                        mk_end[c]   = dec_imm[0];
                        mk_phase[c] = PHASE_W'(dec_imm >> 1);
                    end else begin
                        mk_extra[c] = mk_extra[c] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Per-core phase FSM next state and completed-interval record
    always_comb begin
        for (int c = 0; c < int'(NCORE); c++) begin
            state_d[c] = state_q[c];
            phase_d[c] = phase_q[c];
            start_d[c] = start_q[c];
            push[c]    = 1'b0;
            err_set[c] = (mk_extra[c] != '0);
            rec[c]     = {1'(c), phase_q[c], start_q[c], TS_W'(ts_q - start_q[c])};
            if (mk_hit[c]) begin
                if (state_q[c] == S_IDLE) begin
                    if (mk_end[c]) begin
                        err_set[c] = 1'b1;
                    end else begin
                        state_d[c] = S_ACTIVE;
                        phase_d[c] = mk_phase[c];
                        start_d[c] = ts_q;
                    end
                end else if (mk_end[c] && (mk_phase[c] == phase_q[c])) begin
                    state_d[c] = S_IDLE;
                    push[c]    = 1'b1;
                end else begin
                    err_set[c] = 1'b1;
                end
            end
            if (clear) begin
                done_d[c] = '0;
            end else if (push[c] && (done_q[c] != CNT_MAX)) begin
                done_d[c] = done_q[c] + CNT_W'(1);
            end else begin
                done_d[c] = done_q[c];
            end
        end
    end

    // FIFO admission: space counted after this cycle's pop, base before variant
    always_comb begin
        pop     = (count_q != '0) && ev_ready;
        free0   = CW'(FIFO_DEPTH) - count_q + CW'(pop);
        acc0    = push[0] && (free0 != '0);
        free1   = free0 - CW'(acc0);
        acc1    = push[1] && (free1 != '0);
        lost    = 2'(push[0] && !acc0) + 2'(push[1] && !acc1);
        wr1     = wr_q + AW'(acc0);
        count_d = count_q - CW'(pop) + CW'(acc0) + CW'(acc1);
    end

    // Sticky flags and counters, evaluated on next-state values
    always_comb begin
        drop_sum  = DW'(drop_q) + DW'(mk_extra[0]) + DW'(mk_extra[1]) + DW'(lost);
        drop_d    = clear ? '0 : ((drop_sum > DW'(CNT_MAX)) ? CNT_MAX : CNT_W'(drop_sum));
        err_d     = clear ? 2'b00 : (err_q | {err_set[1], err_set[0]});
        aligned_d = (state_d[0] == S_IDLE) && (state_d[1] == S_IDLE)
                    && (done_d[0] == done_d[1]);
        div_d     = clear ? 1'b0
                    : (div_q | (aligned_d && (done_d[0] != '0)
                                && (phase_d[0] != phase_d[1])));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q      <= '0;
            for (int c = 0; c < int'(NCORE); c++) begin
                state_q[c] <= S_IDLE;
                phase_q[c] <= '0;
                start_q[c] <= '0;
                done_q[c]  <= '0;
            end
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_q      <= '0;
            wr_q      <= '0;
            count_q   <= '0;
            drop_q    <= '0;
            err_q     <= 2'b00;
            div_q     <= 1'b0;
            aligned_q <= 1'b1;
        end else begin
            ts_q <= ts_q + TS_W'(1);
            for (int c = 0; c < int'(NCORE); c++) begin
                state_q[c] <= state_d[c];
                phase_q[c] <= phase_d[c];
                start_q[c] <= start_d[c];
                done_q[c]  <= done_d[c];
            end
            if (acc0) begin
                mem_q[wr_q] <= rec[0];
            end
            if (acc1) begin
                mem_q[wr1] <= rec[1];
            end
            rd_q      <= rd_q + AW'(pop);
            wr_q      <= wr1 + AW'(acc1);
            count_q   <= count_d;
            drop_q    <= drop_d;
            err_q     <= err_d;
            div_q     <= div_d;
            aligned_q <= aligned_d;
        end
    end

    assign ev_valid      = (count_q != '0);
    assign ev_data       = mem_q[rd_q];
    assign base_active   = (state_q[0] == S_ACTIVE);
    assign vnt_active    = (state_q[1] == S_ACTIVE);
    assign base_phase    = phase_q[0];
    assign vnt_phase     = phase_q[1];
    assign base_done_cnt = done_q[0];
    assign vnt_done_cnt  = done_q[1];
    assign aligned       = aligned_q;
    assign diverged      = div_q;
    assign proto_err     = err_q;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_phase_marker_tracker.sv
// Self-checking bench for phase_marker_tracker: directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_phase_marker_tracker;

    localparam int NL     = 2;
    localparam int REC_W  = 68;
    localparam int SREC_W = 12;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                clear = 1'b0;
    logic                ev_ready = 1'b0;
    logic [NL-1:0]       base_valid = '0;
    logic [NL-1:0]       vnt_valid = '0;
    logic [32*NL-1:0]    base_inst = '0;
    logic [32*NL-1:0]    vnt_inst = '0;

    logic                ev_valid;
    logic [REC_W-1:0]    ev_data;
    logic                base_active, vnt_active;
    logic [2:0]          base_phase, vnt_phase;
    logic [15:0]         base_done_cnt, vnt_done_cnt;
    logic                aligned, diverged;
    logic [1:0]          proto_err;
    logic [15:0]         drop_cnt;

    logic                s_ev_valid;
    logic [SREC_W-1:0]   s_ev_data;
    logic                s_base_active, s_vnt_active;
    logic [2:0]          s_base_phase, s_vnt_phase;
    logic [15:0]         s_base_done_cnt, s_vnt_done_cnt;
    logic                s_aligned, s_diverged;
    logic [1:0]          s_proto_err;
    logic [15:0]         s_drop_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [REC_W-1:0] m_q[$];
    bit               m_act   [2];
    int               m_phase [2];
    logic [31:0]      m_start [2];
    int               m_done  [2];
    int               m_drop;
    bit [1:0]         m_err;
    bit               m_div;
    logic [31:0]      m_ts;

    always #5 clk = ~clk;

    phase_marker_tracker u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .base_valid(base_valid), .base_inst(base_inst),
        .vnt_valid(vnt_valid), .vnt_inst(vnt_inst),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
        .base_active(base_active), .vnt_active(vnt_active),
        .base_phase(base_phase), .vnt_phase(vnt_phase),
        .base_done_cnt(base_done_cnt), .vnt_done_cnt(vnt_done_cnt),
        .aligned(aligned), .diverged(diverged),
        .proto_err(proto_err), .drop_cnt(drop_cnt)
    );

    // Narrow-timestamp instance used to observe wrap-around
    phase_marker_tracker #(.TS_W(4)) u_small (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .base_valid(base_valid), .base_inst(base_inst),
        .vnt_valid(vnt_valid), .vnt_inst(vnt_inst),
        .ev_valid(s_ev_valid), .ev_ready(ev_ready), .ev_data(s_ev_data),
        .base_active(s_base_active), .vnt_active(s_vnt_active),
        .base_phase(s_base_phase), .vnt_phase(s_vnt_phase),
        .base_done_cnt(s_base_done_cnt), .vnt_done_cnt(s_vnt_done_cnt),
        .aligned(s_aligned), .diverged(s_diverged),
        .proto_err(s_proto_err), .drop_cnt(s_drop_cnt)
    );

    function automatic logic [31:0] mk(input int ph, input bit is_end);
        return {8'h00, 3'(ph), is_end, 20'h02013};
    endfunction

    function automatic bit is_marker(input logic [31:0] w);
        return (w[19:0] == 20'h02013) && ((w >> 24) == 32'd0) && (((w >> 21) & 32'h7) < 32'd7);
    endfunction

    function automatic int sat(input int x);
        return (x > 65535) ? 65535 : x;
    endfunction

    function automatic logic [31:0] rand_inst();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 6) return mk($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        if (r == 7) return mk(7, 1'($urandom_range(0, 1)));
        if (r == 8) return {4'h0, 4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), 20'h02013};
        return $urandom();
    endfunction

    task automatic model_reset();
        m_q.delete();
        for (int c = 0; c < 2; c++) begin
            m_act[c] = 1'b0; m_phase[c] = 0; m_start[c] = '0; m_done[c] = 0;
        end
        m_drop = 0; m_err = 2'b00; m_div = 1'b0; m_ts = '0;
    endtask

    // One clock of the reference model, using the inputs presented this cycle
    task automatic model_step();
        logic [NL-1:0]    v;
        logic [32*NL-1:0] ins;
        logic [31:0]      w, fw, dur;
        bit               found;
        int               ph;
        if (m_q.size() != 0 && ev_ready) void'(m_q.pop_front());
        for (int c = 0; c < 2; c++) begin
            v = (c == 0) ? base_valid : vnt_valid;
            ins = (c == 0) ? base_inst : vnt_inst;
            found = 1'b0;
            fw = '0;
            for (int l = 0; l < NL; l++) begin
                w = ins[32*l +: 32];
                if (v[l] && is_marker(w)) begin
                    if (!found) begin
                        found = 1'b1; fw = w;
                    end else begin
                        m_drop = sat(m_drop + 1); m_err[c] = 1'b1;
                    end
                end
            end
            if (found) begin
                ph = int'((fw >> 21) & 32'h7);
                if (!m_act[c]) begin
                    if (!fw[20]) begin
                        m_act[c] = 1'b1; m_phase[c] = ph; m_start[c] = m_ts;
                    end else begin
                        m_err[c] = 1'b1;
                    end
                end else if (fw[20] && ph == m_phase[c]) begin
                    m_act[c] = 1'b0;
                    m_done[c] = sat(m_done[c] + 1);
                    dur = m_ts - m_start[c];
                    if (m_q.size() < 8) m_q.push_back({1'(c), 3'(ph), m_start[c], dur});
                    else m_drop = sat(m_drop + 1);
                end else begin
                    m_err[c] = 1'b1;
                end
            end
        end
        if (clear) begin
            m_drop = 0; m_done[0] = 0; m_done[1] = 0; m_err = 2'b00; m_div = 1'b0;
        end else if (m_done[0] == m_done[1] && m_done[0] != 0 && !m_act[0] && !m_act[1]
                     && m_phase[0] != m_phase[1]) begin
            m_div = 1'b1;
        end
        m_ts = m_ts + 32'd1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        base_valid = '0; vnt_valid = '0; base_inst = '0; vnt_inst = '0; clear = 1'b0;
    endtask

    task automatic do_reset();
        base_valid = '0; vnt_valid = '0; base_inst = '0; vnt_inst = '0; clear = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({ev_valid, base_active, vnt_active, base_phase, vnt_phase, aligned, diverged, proto_err} !== 12'b0_0_0_000_000_1_0_00) begin
            n_fail++; $display("FAIL reset_flags got %b", {ev_valid, base_active, vnt_active, base_phase, vnt_phase, aligned, diverged, proto_err});
        end
        n_cmp++;
        if ({base_done_cnt, vnt_done_cnt, drop_cnt} !== 48'd0 || ev_data !== 68'd0) begin
            n_fail++; $display("FAIL reset_counts got %h %h %h data %h exp 0", base_done_cnt, vnt_done_cnt, drop_cnt, ev_data);
        end
        // Open an interval and queue a record, then reset mid-cycle
        ev_ready = 1'b0;
        base_valid = 2'b01; base_inst = {32'h0, mk(1, 0)}; tick();
        base_valid = 2'b01; base_inst = {32'h0, mk(1, 1)}; tick();
        vnt_valid = 2'b01; vnt_inst = {32'h0, mk(2, 0)}; tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ev_valid, base_active, vnt_active, aligned} !== 4'b0001 || base_done_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_midphase got v=%b ba=%b va=%b al=%b done=%0d exp 0 0 0 1 0", ev_valid, base_active, vnt_active, aligned, base_done_cnt);
        end
        do_reset();
    endtask

    task automatic test_vctm();
        do_reset();
        ev_ready = 1'b1;
        while (m_ts != 32'd10) tick();
        base_valid = 2'b01; base_inst = {32'h0, 32'h00002013}; tick();
        n_cmp++;
        if (base_active !== 1'b1 || base_phase !== 3'd0 || aligned !== 1'b0) begin
            n_fail++; $display("FAIL vctm_start got act=%b ph=%0d al=%b exp 1 0 0", base_active, base_phase, aligned);
        end
        while (m_ts != 32'd25) tick();
        base_valid = 2'b01; base_inst = {32'h0, 32'h00102013}; tick();
        n_cmp++;
        if (ev_valid !== 1'b1 || ev_data !== {1'b0, 3'd0, 32'd10, 32'd15}) begin
            n_fail++; $display("FAIL vctm_record got v=%b %h exp %h", ev_valid, ev_data, {1'b0, 3'd0, 32'd10, 32'd15});
        end
        n_cmp++;
        if (base_done_cnt !== 16'd1 || aligned !== 1'b0 || base_active !== 1'b0) begin
            n_fail++; $display("FAIL vctm_done got done=%0d al=%b act=%b exp 1 0 0", base_done_cnt, aligned, base_active);
        end
        vnt_valid = 2'b10; vnt_inst = {mk(0, 0), 32'h0}; tick();
        tick();
        vnt_valid = 2'b01; vnt_inst = {32'h0, mk(0, 1)}; tick();
        n_cmp++;
        if (vnt_done_cnt !== 16'd1 || aligned !== 1'b1 || diverged !== 1'b0) begin
            n_fail++; $display("FAIL vctm_aligned got vdone=%0d al=%b div=%b exp 1 1 0", vnt_done_cnt, aligned, diverged);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] s;
        do_reset();
        ev_ready = 1'b0;
        tick(); tick();
        s = m_ts;
        base_valid = 2'b01; base_inst = {32'h0, mk(2, 0)};
        vnt_valid = 2'b01; vnt_inst = {32'h0, mk(2, 0)};
        tick();
        repeat (3) tick();
        base_valid = 2'b01; base_inst = {32'h0, mk(2, 1)};
        vnt_valid = 2'b01; vnt_inst = {32'h0, mk(2, 1)};
        tick();
        n_cmp++;
        if (ev_valid !== 1'b1 || ev_data !== {1'b0, 3'd2, s, 32'd4}) begin
            n_fail++; $display("FAIL b2b_first got v=%b %h exp %h", ev_valid, ev_data, {1'b0, 3'd2, s, 32'd4});
        end
        n_cmp++;
        if (aligned !== 1'b1 || diverged !== 1'b0) begin
            n_fail++; $display("FAIL b2b_aligned got al=%b div=%b exp 1 0", aligned, diverged);
        end
        ev_ready = 1'b1; tick();
        n_cmp++;
        if (ev_valid !== 1'b1 || ev_data !== {1'b1, 3'd2, s, 32'd4}) begin
            n_fail++; $display("FAIL b2b_second got v=%b %h exp %h", ev_valid, ev_data, {1'b1, 3'd2, s, 32'd4});
        end
        tick();
        n_cmp++;
        if (ev_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_empty got %b exp 0", ev_valid);
        end
    endtask

    task automatic test_diverge();
        do_reset();
        ev_ready = 1'b1;
        base_valid = 2'b01; base_inst = {32'h0, mk(1, 0)};
        vnt_valid = 2'b01; vnt_inst = {32'h0, mk(3, 0)};
        tick();
        base_valid = 2'b01; base_inst = {32'h0, mk(1, 1)};
        vnt_valid = 2'b01; vnt_inst = {32'h0, mk(3, 1)};
        tick();
        n_cmp++;
        if (diverged !== 1'b1 || base_phase !== 3'd1 || vnt_phase !== 3'd3 || aligned !== 1'b1) begin
            n_fail++; $display("FAIL div_set got div=%b bph=%0d vph=%0d al=%b exp 1 1 3 1", diverged, base_phase, vnt_phase, aligned);
        end
        repeat (3) tick();
        n_cmp++;
        if (diverged !== 1'b1) begin
            n_fail++; $display("FAIL div_sticky got %b exp 1", diverged);
        end
        clear = 1'b1; tick();
        n_cmp++;
        if (diverged !== 1'b0 || base_done_cnt !== 16'd0 || vnt_done_cnt !== 16'd0 || aligned !== 1'b1) begin
            n_fail++; $display("FAIL div_clear got div=%b bd=%0d vd=%0d al=%b exp 0 0 0 1", diverged, base_done_cnt, vnt_done_cnt, aligned);
        end
    endtask

    task automatic test_proto();
        do_reset();
        ev_ready = 1'b1;
        base_valid = 2'b01; base_inst = {32'h0, mk(2, 1)}; tick();
        n_cmp++;
        if (proto_err !== 2'b01 || base_active !== 1'b0) begin
            n_fail++; $display("FAIL proto_end_idle got err=%b act=%b exp 01 0", proto_err, base_active);
        end
        base_valid = 2'b01; base_inst = {32'h0, mk(1, 0)}; tick();
        base_valid = 2'b01; base_inst = {32'h0, mk(3, 0)}; tick();
        n_cmp++;
        if (proto_err !== 2'b01 || base_active !== 1'b1 || base_phase !== 3'd1) begin
            n_fail++; $display("FAIL proto_start_active got err=%b act=%b ph=%0d exp 01 1 1", proto_err, base_active, base_phase);
        end
        base_valid = 2'b11; base_inst = {mk(5, 0), mk(4, 0)}; tick();
        n_cmp++;
        if (drop_cnt !== 16'd1 || proto_err !== 2'b01 || base_phase !== 3'd1) begin
            n_fail++; $display("FAIL proto_two_lanes got drop=%0d err=%b ph=%0d exp 1 01 1", drop_cnt, proto_err, base_phase);
        end
        // Non-markers (imm high bits set, phase 7, invalid lane) are ignored
        vnt_valid = 2'b11; vnt_inst = {32'h00F02013, 32'h01102013}; tick();
        vnt_valid = 2'b00; vnt_inst = {32'h0, mk(0, 0)}; tick();
        n_cmp++;
        if (proto_err !== 2'b01 || drop_cnt !== 16'd1 || vnt_active !== 1'b0) begin
            n_fail++; $display("FAIL proto_ignore got err=%b drop=%0d vact=%b exp 01 1 0", proto_err, drop_cnt, vnt_active);
        end
    endtask

    task automatic test_fifo_full();
        logic [REC_W-1:0] exp_q[$];
        logic [31:0] s;
        do_reset();
        ev_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s = m_ts;
            base_valid = 2'b01; base_inst = {32'h0, mk(0, 0)}; tick();
            base_valid = 2'b01; base_inst = {32'h0, mk(0, 1)}; tick();
            if (exp_q.size() < 8) exp_q.push_back({1'b0, 3'd0, s, 32'd1});
        end
        n_cmp++;
        if (drop_cnt !== 16'd2 || ev_valid !== 1'b1 || ev_data !== exp_q[0]) begin
            n_fail++; $display("FAIL full_drop got drop=%0d v=%b %h exp 2 1 %h", drop_cnt, ev_valid, ev_data, exp_q[0]);
        end
        s = m_ts;
        base_valid = 2'b01; base_inst = {32'h0, mk(4, 0)}; tick();
        ev_ready = 1'b1;
        base_valid = 2'b01; base_inst = {32'h0, mk(4, 1)}; tick();
        void'(exp_q.pop_front());
        exp_q.push_back({1'b0, 3'd4, s, 32'd1});
        n_cmp++;
        if (drop_cnt !== 16'd2) begin
            n_fail++; $display("FAIL full_pop_push got drop=%0d exp 2", drop_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (ev_valid !== 1'b1 || ev_data !== exp_q[i]) begin
                n_fail++; $display("FAIL drain_%0d got v=%b %h exp %h", i, ev_valid, ev_data, exp_q[i]);
            end
            tick();
        end
        n_cmp++;
        if (ev_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_empty got %b exp 0", ev_valid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        ev_ready = 1'b0;
        while (m_ts != 32'd13) tick();
        base_valid = 2'b01; base_inst = {32'h0, mk(2, 0)}; tick();
        while (m_ts != 32'd20) tick();
        base_valid = 2'b01; base_inst = {32'h0, mk(2, 1)}; tick();
        n_cmp++;
        if (s_ev_valid !== 1'b1 || s_ev_data !== {1'b0, 3'd2, 4'd13, 4'd7}) begin
            n_fail++; $display("FAIL wrap_small got v=%b %h exp %h", s_ev_valid, s_ev_data, {1'b0, 3'd2, 4'd13, 4'd7});
        end
        n_cmp++;
        if (ev_data !== {1'b0, 3'd2, 32'd13, 32'd7}) begin
            n_fail++; $display("FAIL wrap_wide got %h exp %h", ev_data, {1'b0, 3'd2, 32'd13, 32'd7});
        end
    endtask

    task automatic test_random();
        logic [11:0] st_got, st_exp;
        logic [47:0] cn_got, cn_exp;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            base_valid = NL'($urandom_range(0, 3));
            vnt_valid  = NL'($urandom_range(0, 3));
            base_inst  = {rand_inst(), rand_inst()};
            vnt_inst   = {rand_inst(), rand_inst()};
            clear      = ($urandom_range(0, 99) == 0);
            ev_ready   = ((cyc / 200) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            tick();
            st_got = {base_active, vnt_active, base_phase, vnt_phase, aligned, diverged, proto_err};
            st_exp = {m_act[0], m_act[1], 3'(m_phase[0]), 3'(m_phase[1]),
                      !m_act[0] && !m_act[1] && (m_done[0] == m_done[1]), m_div, m_err};
            n_cmp++;
            if (st_got !== st_exp) begin
                n_fail++; $display("FAIL rnd_status cyc=%0d got %b exp %b", cyc, st_got, st_exp);
            end
            cn_got = {base_done_cnt, vnt_done_cnt, drop_cnt};
            cn_exp = {16'(m_done[0]), 16'(m_done[1]), 16'(m_drop)};
            n_cmp++;
            if (cn_got !== cn_exp) begin
                n_fail++; $display("FAIL rnd_counts cyc=%0d got %h exp %h", cyc, cn_got, cn_exp);
            end
            n_cmp++;
            if (ev_valid !== (m_q.size() != 0)) begin
                n_fail++; $display("FAIL rnd_ev_valid cyc=%0d got %b exp %b", cyc, ev_valid, (m_q.size() != 0));
            end else if (m_q.size() != 0) begin
                n_cmp++;
                if (ev_data !== m_q[0]) begin
                    n_fail++; $display("FAIL rnd_ev_data cyc=%0d got %h exp %h", cyc, ev_data, m_q[0]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_vctm();
        test_back_to_back();
        test_diverge();
        test_proto();
        test_fifo_full();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_marker_tracker.md
# phase_marker_tracker

- Synthesizable, parametrised tracker for the phase-marker instructions that bracket fuzzing phases on two lock-stepped cores: base (DUT) and variant.
- Watches both cores' multi-lane commit streams and decodes marker encodings into per-core phase state machines.
- Emits timestamped, complete phase-interval records through a valid/ready event FIFO.
- Flags protocol errors and base/variant phase divergence. Sits beside the ROB commit taps in the sim/FPGA harness.

## Interface
- NUM_LANES, 2: commit lanes per core.
- TS_W, 32: timestamp / duration width.
- FIFO_DEPTH, 8: event FIFO entries; power of two, ≥2.
- NUM_PHASES, 7: legal phase ids 0..NUM_PHASES-1 (0 VCTM, 1 DELAY, 2 TEXE, 3 LEAK, 4 INIT, 5 BIM, 6 TRAIN).
- PHASE_W, 3: phase id width.
- CNT_W, 16: counter width.
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low.
- clear  in  1  synchronous clear of sticky flags and counters; the FIFO and FSMs are untouched.
- base_valid  in  NUM_LANES  base commit valid per lane.
- base_inst  in  32*NUM_LANES  base lane i instruction at [32i+31:32i].
- vnt_valid / vnt_inst  in  NUM_LANES / 32*NUM_LANES  same, for the variant core.
- ev_valid  out  1  FIFO non-empty.
- ev_ready  in  1  consumer accepts the head record.
- ev_data  out  1+PHASE_W+2*TS_W  {core, phase, start_ts, duration}, MSB first; core 0 = base.
- base_active, vnt_active  out  1  core currently inside a phase.
- base_phase, vnt_phase  out  PHASE_W  current or last phase id.
- base_done_cnt, vnt_done_cnt  out  CNT_W  completed phases, saturating.
- aligned  out  1  both cores idle and done counts equal.
- diverged  out  1  sticky.
- proto_err  out  2  sticky; bit0 base, bit1 variant.
- drop_cnt  out  CNT_W  saturating count of markers ignored or records lost.

## Operation
- **Marker decode:** valid lane with inst[19:0]==20'h02013 (slti x0,x0,imm).
  - imm=inst[31:20]; phase=imm[PHASE_W:1]; imm[0]=0 is START, imm[0]=1 is END.
  - imm[11:PHASE_W+1]≠0 or phase≥NUM_PHASES: not a marker, ignored silently.
- **Per core, per cycle:** only the lowest-index marker lane is taken. Each additional marker lane in that cycle increments drop_cnt and sets proto_err for that core.
- **Timestamp counter** ts: TS_W bits, reset 0, +1 every cycle, wraps.
- **Core FSM IDLE:**
  - START p → ACTIVE; phase←p, start_ts←ts.
  - END → proto_err set; stay IDLE.
- **Core FSM ACTIVE(p):**
  - END p → IDLE; done_cnt+1; push record {core,p,start_ts,ts-start_ts mod 2^TS_W}.
  - END q≠p or any START → proto_err set; state unchanged.
- **FIFO:** 2 write ports, 1 read port. Base record is written before variant record in the same cycle.
  - Free slots are counted after this cycle's pop.
  - A record that does not fit is dropped (variant dropped first) and drop_cnt increments per lost record.
- **Pop** when ev_valid&&ev_ready.
- **diverged:** set when the two done counts are equal and nonzero and base_phase≠vnt_phase, both cores IDLE.
- **Saturating counters:** hold at 2^CNT_W-1.
- **clear:** zeroes drop_cnt, done counts, proto_err, diverged. Simultaneous events in the clear cycle are discarded from the counters.

## Timing
- **Reset values:** ts=0, FSMs IDLE, phase=0, ev_valid=0, ev_data=0, all counts 0, flags 0, aligned=1.
- Marker in cycle t → active/phase/done_cnt/flags update at t+1; its record is visible on ev_valid at t+1 at the earliest.
- start_ts and the end timestamp are the ts values in the marker's commit cycle. START at t, END at t+5 → duration 5.
- Full FIFO with ev_ready=1: pop and push in the same cycle, no loss for one record.
- ev_data is stable while ev_valid&&!ev_ready.
- Asynchronous reset mid-phase discards all open intervals and FIFO contents.

## Test plan
- Base START VCTM (0x00002013) at ts=10, END (0x00102013) at ts=25, ev_ready=1 → one record {0,0,10,15}; base_done_cnt=1; aligned=0 until the variant completes VCTM.
- Both cores run TEXE START/END in the same cycles → two records in order base then variant; aligned=1; diverged=0.
- Base completes DELAY, variant completes LEAK, counts equal → diverged=1 and stays 1 until clear.
- END TEXE while IDLE; START LEAK while in DELAY → proto_err=2'b01, base still in DELAY; two markers on lanes 0 and 1 in one cycle → drop_cnt=1.
- ev_ready=0, FIFO_DEPTH=8, ten END records pushed → 8 stored, drop_cnt=2; records drain in order.
- START at ts=2^TS_W-3, END at ts=4 after wrap → duration 7.
